pll_reset_ctrl: RTL

Reset and lock supervisor for the board PLL, running on the free-running reference clock. Drives the PLL `rst` input, consumes its asynchronous `locked` output, and releases a system reset only after lock has been stable for a programmable interval. On lock loss, timeout or software request it re-asserts the system reset, retries, and counts the events for software.

---
 rtl/pll_reset_ctrl_pkg.sv | 20 ++
 rtl/pll_reset_ctrl_sync2.sv | 24 ++
 rtl/pll_reset_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/pll_reset_ctrl_pkg.sv
// Shared types and constants for the PLL reset and lock supervisor.
// Supervisor states and the saturating event-counter helper.
package pll_reset_ctrl_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [7:0] SAT_MAX = 8'd255;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == SAT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pll_reset_ctrl_sync2.sv
// Two-flop single-bit synchronizer with a parameterised reset value.
// Reusable for any slow asynchronous status input.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset pulse generator and lock qualifier driving the system reset.
// One shared cycle counter serves all states; events counted for software.
module pll_reset_ctrl
  import pll_reset_ctrl_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 100000,
  parameter int CNT_W        = 17
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       force_reset,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [7:0] relock_cnt,
  output logic [7:0] timeout_cnt
);

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);

  logic             locked_s;
  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [7:0]       relock_n;
  logic [7:0]       timeout_n;

  sync2 #(
    .RST_VAL(1'b0)
  ) u_sync (
    .clk(refclk),
    .rst(rst),
    .d  (pll_locked),
    .q  (locked_s)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + ONE;
    relock_n  = relock_cnt;
    timeout_n = timeout_cnt;
    if (force_reset) begin
      state_n = PLL_RST;
      cnt_n   = '0;
    end else begin
      unique case (state)
        PLL_RST: begin
          if (cnt == RST_LAST) begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_n = STABLE;
            cnt_n   = '0;
          end else if (cnt == TMO_LAST) begin
            state_n   = PLL_RST;
            cnt_n     = '0;
            timeout_n = sat_inc(timeout_cnt);
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
          end else if (cnt == STB_LAST) begin
            state_n = RUN;
            cnt_n   = '0;
          end
        end
        RUN: begin
          // The PLL is left running; WAIT_LOCK's timeout handles no-recovery.
          cnt_n = '0;
          if (!locked_s) begin
            state_n  = WAIT_LOCK;
            relock_n = sat_inc(relock_cnt);
          end
        end
        default: begin
          state_n = PLL_RST;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= PLL_RST;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      relock_cnt  <= 8'd0;
      timeout_cnt <= 8'd0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pll_rst     <= (state_n == PLL_RST);
      sys_rst     <= (state_n != RUN);
      ready       <= (state_n == RUN);
      relock_cnt  <= relock_n;
      timeout_cnt <= timeout_n;
    end
  end

endmodule
